decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline, sitting directly downstream of regfile.
- Decodes the IF/ID instruction and drives the regfile read addresses.
- Bypasses the same-cycle WB write, because regfile writes at posedge and reads return the old value.
- Detects load-use hazards and registers all operands and control into the ID/EX pipeline register.

Parameters:
- RESET_PC, 32'h0, value loaded into id_ex_pc on reset.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- stall  input  1  global freeze; same signal that gates regfile writes
- flush  input  1  branch/jump resolved in EX; squash instruction in ID
- if_valid  input  1  IF/ID holds a real instruction
- if_instr  input  32  IF/ID instruction
- if_pc  input  32  IF/ID PC
- RAddr1_RF  output  5  equals instr[25:21] (rs), combinational
- RAddr2_RF  output  5  equals instr[20:16] (rt), combinational
- RD1_RF / RD2_RF  input  32  regfile read data
- WAddr_RF, WrEn_RF, WD_RF  input  5/1/32  snooped WB write port
- load_use_stall  output  1  combinational; IF and IF/ID must hold
- id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite  output  1 each
- id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm  output  32 each
- id_ex_rs, id_ex_rt, id_ex_dest, id_ex_shamt  output  5 each
- id_ex_opcode, id_ex_funct  output  6 each

Behaviour:
- Decode (opcode):
  - 0x00 R-type: dest=rd; regwrite=1 except funct 0x08 (JR).
  - 0x23 LW: dest=rt, regwrite, memread.
  - 0x2B SW: memwrite only.
  - 0x08-0x0B ADDI/ADDIU/SLTI/SLTIU: dest=rt, sign-extended imm.
  - 0x0C-0x0E ANDI/ORI/XORI: dest=rt, zero-extended imm.
  - 0x0F LUI: dest=rt, imm={instr[15:0],16'h0}.
  - 0x04/0x05 BEQ/BNE: no write, sign-extended imm.
  - 0x02 J: no write.
  - 0x03 JAL: dest=31, regwrite.
  - Unknown opcodes: all control 0, valid kept.
- If dest==0, regwrite is forced to 0.
- uses_rt=1 for R-type, SW, BEQ, BNE; rs is treated as used for every opcode except J, JAL and LUI.
- Bypass: if WrEn_RF && WAddr_RF!=0 && WAddr_RF==rs, rs_data=WD_RF, else RD1_RF. rt is handled the same way with RD2_RF. Register 0 always reads as 0.
- load_use_stall = if_valid && id_ex_valid && id_ex_memread && id_ex_dest!=0 && !flush && ((rs_used && id_ex_dest==rs) || (uses_rt && id_ex_dest==rt)).
- ID/EX update at posedge, priority order:
  1. reset: all outputs 0, id_ex_pc=RESET_PC.
  2. stall: hold every register.
  3. flush: bubble (valid and all control 0; data fields don't-care, driven 0).
  4. load_use_stall: bubble.
  5. else: capture decoded fields; valid=if_valid. When if_valid=0, all control is 0.
- Latency: 1 cycle from IF/ID to ID/EX.
- A load-use bubble lasts exactly 1 cycle. The next cycle the load has moved to MEM, so ID/EX no longer holds a load targeting rs/rt.
- stall and flush together: stall wins and flush must be re-presented by EX; EX holds it because EX is frozen.
- Reset asserted mid-stall clears state immediately.

Test Plan:
- Reset, then ADDI $5,$0,7 (0x20050007) with if_valid -> next cycle id_ex_valid=1, regwrite=1, dest=5, imm=7, rs_data=0.
- LW $3,0($1) followed by ADD $4,$3,$2 -> load_use_stall=1 for one cycle; ID/EX gets a bubble, then the ADD is captured with rs=3.
- WB writes $7=0xDEADBEEF (WrEn_RF=1) while ID decodes OR $8,$7,$7 -> id_ex_rs_data=id_ex_rt_data=0xDEADBEEF. Repeat with WAddr_RF=0 -> RD values are used.
- ORI $2,$0,0xFFFF -> imm=0x0000FFFF; ADDI $2,$0,-1 -> imm=0xFFFFFFFF; LUI $2,0x1234 -> imm=0x12340000.
- stall=1 for 3 cycles with changing if_instr -> ID/EX unchanged; flush=1 with stall=0 -> id_ex_valid=0, regwrite=0; flush concurrent with a load-use case -> load_use_stall=0.
- JAL -> dest=31, regwrite=1; ADD $0,$1,$2 -> regwrite=0; JR $31 -> regwrite=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - ID/EX pipeline register bundle between decode and execute
interface decode_stage_if;
    logic        id_ex_valid;
    logic        id_ex_regwrite;
    logic        id_ex_memread;
    logic        id_ex_memwrite;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs_data;
    logic [31:0] id_ex_rt_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_dest;
    logic [4:0]  id_ex_shamt;
    logic [5:0]  id_ex_opcode;
    logic [5:0]  id_ex_funct;

    // Decode stage drives the register; execute consumes it.
    modport master (
        output id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
        output id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
        output id_ex_rs, id_ex_rt, id_ex_dest, id_ex_shamt,
        output id_ex_opcode, id_ex_funct
    );
    modport slave (
        input id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
        input id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
        input id_ex_rs, id_ex_rt, id_ex_dest, id_ex_shamt,
        input id_ex_opcode, id_ex_funct
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: decode, WB bypass, load-use detect, ID/EX register
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [31:0]        if_pc,
    output logic [4:0]         RAddr1_RF,
    output logic [4:0]         RAddr2_RF,
    input  logic [31:0]        RD1_RF,
    input  logic [31:0]        RD2_RF,
    input  logic [4:0]         WAddr_RF,
    input  logic               WrEn_RF,
    input  logic [31:0]        WD_RF,
    output logic               load_use_stall,
    decode_stage_if.master     id_ex
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;

    logic [4:0]  dest;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [31:0] imm;
    logic        uses_rt;
    logic        rs_used;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    assign opcode    = if_instr[31:26];
    assign rs        = if_instr[25:21];
    assign rt        = if_instr[20:16];
    assign rd        = if_instr[15:11];
    assign shamt     = if_instr[10:6];
    assign funct     = if_instr[5:0];
    assign RAddr1_RF = rs;
    assign RAddr2_RF = rt;

    // Opcode decode into destination, control bits, immediate and operand usage.
    always_comb begin
        dest     = 5'd0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        imm      = {{16{if_instr[15]}}, if_instr[15:0]};
        uses_rt  = 1'b0;
        rs_used  = 1'b1;
        case (opcode)
            6'h00: begin
                dest     = rd;
                regwrite = (funct != 6'h08);
                uses_rt  = 1'b1;
            end
            6'h23: begin
                dest     = rt;
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            6'h2B: begin
                memwrite = 1'b1;
                uses_rt  = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                dest     = rt;
                regwrite = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dest     = rt;
                regwrite = 1'b1;
                imm      = {16'h0, if_instr[15:0]};
            end
            6'h0F: begin
                dest     = rt;
                regwrite = 1'b1;
                imm      = {if_instr[15:0], 16'h0};
                rs_used  = 1'b0;
            end
            6'h04, 6'h05: begin
                uses_rt  = 1'b1;
            end
            6'h02: begin
                rs_used  = 1'b0;
            end
            6'h03: begin
                dest     = 5'd31;
                regwrite = 1'b1;
                rs_used  = 1'b0;
            end
            default: begin
                dest     = 5'd0;
            end
        endcase
        if (dest == 5'd0) begin
            regwrite = 1'b0;
        end
    end

    // Forward the WB write happening this cycle, since the regfile still returns the old value.
    always_comb begin
        rs_data = RD1_RF;
        rt_data = RD2_RF;
        if (rs == 5'd0) begin
            rs_data = 32'h0;
        end else if (WrEn_RF && WAddr_RF == rs) begin
            rs_data = WD_RF;
        end
        if (rt == 5'd0) begin
            rt_data = 32'h0;
        end else if (WrEn_RF && WAddr_RF == rt) begin
            rt_data = WD_RF;
        end
    end

    // A load in EX cannot forward to an instruction in ID; hold IF/ID for one cycle.
    always_comb begin
        load_use_stall = if_valid && id_ex.id_ex_valid && id_ex.id_ex_memread &&
                         (id_ex.id_ex_dest != 5'd0) && !flush &&
                         ((rs_used && id_ex.id_ex_dest == rs) ||
                          (uses_rt && id_ex.id_ex_dest == rt));
    end

    // ID/EX register: reset, then freeze, then bubble on flush or load-use, else capture.
    always_ff @(posedge clk) begin
        if (reset || (!stall && (flush || load_use_stall))) begin
            id_ex.id_ex_valid    <= 1'b0;
            id_ex.id_ex_regwrite <= 1'b0;
            id_ex.id_ex_memread  <= 1'b0;
            id_ex.id_ex_memwrite <= 1'b0;
            id_ex.id_ex_pc       <= reset ? RESET_PC : 32'h0;
            id_ex.id_ex_rs_data  <= 32'h0;
            id_ex.id_ex_rt_data  <= 32'h0;
            id_ex.id_ex_imm      <= 32'h0;
            id_ex.id_ex_rs       <= 5'd0;
            id_ex.id_ex_rt       <= 5'd0;
            id_ex.id_ex_dest     <= 5'd0;
            id_ex.id_ex_shamt    <= 5'd0;
            id_ex.id_ex_opcode   <= 6'd0;
            id_ex.id_ex_funct    <= 6'd0;
        end else if (!stall) begin
            id_ex.id_ex_valid    <= if_valid;
            id_ex.id_ex_regwrite <= if_valid && regwrite;
            id_ex.id_ex_memread  <= if_valid && memread;
            id_ex.id_ex_memwrite <= if_valid && memwrite;
            id_ex.id_ex_pc       <= if_pc;
            id_ex.id_ex_rs_data  <= rs_data;
            id_ex.id_ex_rt_data  <= rt_data;
            id_ex.id_ex_imm      <= imm;
            id_ex.id_ex_rs       <= rs;
            id_ex.id_ex_rt       <= rt;
            id_ex.id_ex_dest     <= dest;
            id_ex.id_ex_shamt    <= shamt;
            id_ex.id_ex_opcode   <= opcode;
            id_ex.id_ex_funct    <= funct;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  RAddr1_RF;
    logic [4:0]  RAddr2_RF;
    logic [31:0] RD1_RF;
    logic [31:0] RD2_RF;
    logic [4:0]  WAddr_RF;
    logic        WrEn_RF;
    logic [31:0] WD_RF;
    logic        load_use_stall;

    int errors = 0;
    int checks = 0;

    decode_stage_if idex ();

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .RAddr1_RF      (RAddr1_RF),
        .RAddr2_RF      (RAddr2_RF),
        .RD1_RF         (RD1_RF),
        .RD2_RF         (RD2_RF),
        .WAddr_RF       (WAddr_RF),
        .WrEn_RF        (WrEn_RF),
        .WD_RF          (WD_RF),
        .load_use_stall (load_use_stall),
        .id_ex          (idex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] instr, input logic [31:0] pc);
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
        if_instr = 32'h0; if_pc = 32'h0;
        RD1_RF = 32'h5555_5555; RD2_RF = 32'h6666_6666;
        WAddr_RF = 5'd0; WrEn_RF = 1'b0; WD_RF = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'h0, idex.id_ex_valid}, 32'h0);
        chk("rst_pc", idex.id_ex_pc, RST_PC);
        chk("rst_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h0);
        chk("rst_dest", {27'h0, idex.id_ex_dest}, 32'h0);
        reset = 1'b0;

        // ADDI $5,$0,7 : rs reads as zero even though RD1 is nonzero
        if_valid = 1'b1;
        put(32'h2005_0007, 32'h0000_0004);
        chk("raddr1", {27'h0, RAddr1_RF}, 32'd0);
        chk("raddr2", {27'h0, RAddr2_RF}, 32'd5);
        tick();
        chk("addi_valid", {31'h0, idex.id_ex_valid}, 32'h1);
        chk("addi_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h1);
        chk("addi_dest", {27'h0, idex.id_ex_dest}, 32'd5);
        chk("addi_imm", idex.id_ex_imm, 32'd7);
        chk("addi_rs_data", idex.id_ex_rs_data, 32'h0);
        chk("addi_pc", idex.id_ex_pc, 32'h4);

        // LW $3,0($1) then ADD $4,$3,$2 -> one bubble
        put(32'h8C23_0000, 32'h8);
        tick();
        chk("lw_memread", {31'h0, idex.id_ex_memread}, 32'h1);
        chk("lw_dest", {27'h0, idex.id_ex_dest}, 32'd3);
        put(32'h0062_2020, 32'hC);
        chk("lu_stall_on", {31'h0, load_use_stall}, 32'h1);
        tick();
        chk("lu_bubble_valid", {31'h0, idex.id_ex_valid}, 32'h0);
        chk("lu_bubble_memread", {31'h0, idex.id_ex_memread}, 32'h0);
        chk("lu_stall_off", {31'h0, load_use_stall}, 32'h0);
        tick();
        chk("add_valid", {31'h0, idex.id_ex_valid}, 32'h1);
        chk("add_rs", {27'h0, idex.id_ex_rs}, 32'd3);
        chk("add_dest", {27'h0, idex.id_ex_dest}, 32'd4);
        chk("add_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h1);

        // OR $8,$7,$7 with same-cycle WB write of $7
        RD1_RF = 32'h1111_1111; RD2_RF = 32'h2222_2222;
        WrEn_RF = 1'b1; WAddr_RF = 5'd7; WD_RF = 32'hDEAD_BEEF;
        put(32'h00E7_4025, 32'h10);
        tick();
        chk("byp_rs", idex.id_ex_rs_data, 32'hDEAD_BEEF);
        chk("byp_rt", idex.id_ex_rt_data, 32'hDEAD_BEEF);
        WAddr_RF = 5'd0;
        tick();
        chk("nobyp_rs", idex.id_ex_rs_data, 32'h1111_1111);
        chk("nobyp_rt", idex.id_ex_rt_data, 32'h2222_2222);
        WrEn_RF = 1'b0;

        // Immediate forms
        put(32'h3402_FFFF, 32'h14);
        tick();
        chk("ori_imm", idex.id_ex_imm, 32'h0000_FFFF);
        put(32'h2002_FFFF, 32'h18);
        tick();
        chk("addi_neg_imm", idex.id_ex_imm, 32'hFFFF_FFFF);
        put(32'h3C02_1234, 32'h1C);
        tick();
        chk("lui_imm", idex.id_ex_imm, 32'h1234_0000);

        // Stall holds ID/EX for 3 cycles while IF/ID changes
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(32'h2005_0000 + i, 32'h40 + 4 * i);
            tick();
            chk("stall_imm", idex.id_ex_imm, 32'h1234_0000);
            chk("stall_pc", idex.id_ex_pc, 32'h1C);
        end
        stall = 1'b0;

        // Flush -> bubble
        flush = 1'b1;
        put(32'h2005_0007, 32'h20);
        tick();
        chk("flush_valid", {31'h0, idex.id_ex_valid}, 32'h0);
        chk("flush_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h0);
        flush = 1'b0;

        // Flush masks a load-use hazard
        put(32'h8C23_0000, 32'h24);
        tick();
        put(32'h0062_2020, 32'h28);
        chk("lu_noflush", {31'h0, load_use_stall}, 32'h1);
        flush = 1'b1;
        #1;
        chk("lu_flush", {31'h0, load_use_stall}, 32'h0);
        tick();
        chk("lu_flush_valid", {31'h0, idex.id_ex_valid}, 32'h0);
        flush = 1'b0;

        // SW, JAL, ADD to $0, JR
        put(32'hAC23_0004, 32'h2C);
        tick();
        chk("sw_memwrite", {31'h0, idex.id_ex_memwrite}, 32'h1);
        chk("sw_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h0);
        put(32'h0C00_0010, 32'h30);
        tick();
        chk("jal_dest", {27'h0, idex.id_ex_dest}, 32'd31);
        chk("jal_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h1);
        put(32'h0022_0020, 32'h34);
        tick();
        chk("add0_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h0);
        chk("add0_valid", {31'h0, idex.id_ex_valid}, 32'h1);
        put(32'h03E0_0008, 32'h38);
        tick();
        chk("jr_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h0);
        chk("jr_rs", {27'h0, idex.id_ex_rs}, 32'd31);

        // Invalid IF/ID slot carries no control
        if_valid = 1'b0;
        put(32'h2005_0007, 32'h3C);
        tick();
        chk("inv_valid", {31'h0, idex.id_ex_valid}, 32'h0);
        chk("inv_regwrite", {31'h0, idex.id_ex_regwrite}, 32'h0);

        // Valid instruction, then reset during stall clears immediately
        if_valid = 1'b1;
        tick();
        chk("pre_rst_valid", {31'h0, idex.id_ex_valid}, 32'h1);
        stall = 1'b1; reset = 1'b1;
        tick();
        chk("rst_stall_valid", {31'h0, idex.id_ex_valid}, 32'h0);
        chk("rst_stall_pc", idex.id_ex_pc, RST_PC);
        stall = 1'b0; reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
